// File: rtl/adda_capture_ctrl.sv
// AD/DA sequencer for the ULX3S J2 converter pair. It divides the clock into the conversion clocks,
// selects the DAC source, runs a triggered single-shot capture and streams the buffer out over valid/ready.
module adda_capture_ctrl #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DEPTH_LOG2 = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_arm,
  input  logic       i_abort,
  input  logic       i_force,
  input  logic [7:0] i_trig_level,
  input  logic       i_trig_rise,
  input  logic [1:0] i_da_src,
  input  logic [7:0] i_da_value,
  output logic       o_J2_AD_CLK,
  input  logic [7:0] i_J2_AD_PORT,
  output logic       o_J2_DA_CLK,
  output logic [7:0] o_J2_DA_PORT,
  output logic [7:0] o_rd_data,
  output logic       o_rd_valid,
  output logic       o_rd_last,
  input  logic       i_rd_ready,
  output logic [1:0] o_state
);

  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam int unsigned AW = DEPTH_LOG2;
  localparam int unsigned N  = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] CNT_TICK  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_DTICK = CW'(CLK_DIV / 2 - 1);
  localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  logic [CW-1:0] r_cnt;
  logic          r_ad_clk;
  logic          r_da_clk;
  logic [7:0]    r_da_port;
  logic [7:0]    r_ad_sample;
  logic [7:0]    r_ramp;
  state_t        r_state;
  logic [AW-1:0] r_wr_addr;
  logic [AW-1:0] r_rd_addr;
  logic          r_force_pend;
  logic [7:0]    r_rd_data;
  logic          r_rd_valid;
  logic          r_rd_last;
  logic [7:0]    r_mem [N];

  logic          w_tick;
  logic          w_dtick;
  logic          w_cross;
  state_t        w_state_nxt;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr_nxt;
  logic [AW-1:0] w_rd_addr_nxt;
  logic          w_force_nxt;
  logic          w_rd_load;
  logic          w_rd_valid_nxt;
  logic          w_rd_last_nxt;

  assign w_tick  = (r_cnt == CNT_TICK);
  assign w_dtick = (r_cnt == CNT_DTICK);
  // Crossing compares the previous conversion against the one being latched at this tick.
  assign w_cross = i_trig_rise ? ((r_ad_sample <  i_trig_level) && (i_J2_AD_PORT >= i_trig_level))
                               : ((r_ad_sample >= i_trig_level) && (i_J2_AD_PORT <  i_trig_level));

  // Conversion clock divider, ADC sampling and DAC source mux.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= CNT_TICK;
      r_ad_clk    <= 1'b0;
      r_da_clk    <= 1'b0;
      r_da_port   <= 8'h80;
      r_ad_sample <= 8'h00;
      r_ramp      <= 8'h00;
    end else begin
      if (w_tick) begin
        r_cnt       <= '0;
        r_ad_clk    <= 1'b1;
        r_da_clk    <= 1'b1;
        r_ad_sample <= i_J2_AD_PORT;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      // DAC data changes on the falling conversion clock so it is settled before the next rise.
      if (w_dtick) begin
        r_ad_clk <= 1'b0;
        r_da_clk <= 1'b0;
        case (i_da_src)
          2'd0: r_da_port <= r_ad_sample;
          2'd1: r_da_port <= i_da_value;
          2'd2: begin
            r_da_port <= r_ramp;
            r_ramp    <= r_ramp + 8'd1;
          end
          default: r_da_port <= 8'hFF - r_ad_sample;
        endcase
      end
    end
  end

  // Capture/readout next-state logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en        = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_rd_addr_nxt  = r_rd_addr;
    w_force_nxt    = r_force_pend;
    w_rd_load      = 1'b0;
    w_rd_valid_nxt = r_rd_valid;
    w_rd_last_nxt  = r_rd_last;
    unique case (r_state)
      S_IDLE: begin
        w_wr_addr_nxt = '0;
        w_rd_addr_nxt = '0;
        w_force_nxt   = 1'b0;
        if (i_arm) w_state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (w_tick) begin
          w_force_nxt = 1'b0;
          if (i_force || r_force_pend || w_cross) begin
            w_state_nxt   = S_CAPTURE;
            w_wr_en       = 1'b1;
            w_wr_addr_nxt = AW'(1);
          end
        end else if (i_force) begin
          w_force_nxt = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (w_tick) begin
          w_wr_en       = 1'b1;
          w_wr_addr_nxt = r_wr_addr + AW'(1);
          if (r_wr_addr == ADDR_LAST) begin
            w_state_nxt   = S_READOUT;
            w_rd_addr_nxt = '0;
          end
        end
      end
      S_READOUT: begin
        if (r_rd_valid && i_rd_ready && r_rd_last) begin
          w_state_nxt    = S_IDLE;
          w_rd_valid_nxt = 1'b0;
          w_rd_last_nxt  = 1'b0;
        end else if (!r_rd_valid || i_rd_ready) begin
          w_rd_load      = 1'b1;
          w_rd_valid_nxt = 1'b1;
          w_rd_last_nxt  = (r_rd_addr == ADDR_LAST);
          w_rd_addr_nxt  = r_rd_addr + AW'(1);
        end
      end
    endcase
    if (i_abort) begin
      w_state_nxt    = S_IDLE;
      w_wr_en        = 1'b0;
      w_force_nxt    = 1'b0;
      w_rd_load      = 1'b0;
      w_rd_valid_nxt = 1'b0;
      w_rd_last_nxt  = 1'b0;
    end
  end

  // State and readout registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wr_addr    <= '0;
      r_rd_addr    <= '0;
      r_force_pend <= 1'b0;
      r_rd_data    <= 8'h00;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_addr    <= w_wr_addr_nxt;
      r_rd_addr    <= w_rd_addr_nxt;
      r_force_pend <= w_force_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_rd_last    <= w_rd_last_nxt;
      if (w_rd_load) r_rd_data <= r_mem[r_rd_addr];
    end
  end

  // Capture buffer keeps its contents across reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_rst) r_mem[r_wr_addr] <= i_J2_AD_PORT;
  end

  assign o_J2_AD_CLK  = r_ad_clk;
  assign o_J2_DA_CLK  = r_da_clk;
  assign o_J2_DA_PORT = r_da_port;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_last    = r_rd_last;
  assign o_state      = 2'(r_state);

endmodule
